// File: rtl/mem_read_arb.sv
// ---------------------------------------------------------------------------
// mem_read_arb
//
// Purpose:
//   Arbitrates two read requesters (instruction fetch and load/store unit)
//   onto a single AXI-style read master port. Only one read is in flight at a
//   time. The FSM walks IDLE -> ADDR -> DATA -> IDLE. The last beat of the
//   read response is captured into the granted requester's data register,
//   and that requester's valid strobe pulses for one cycle.
//
// Build option:
//   MEM_READ_ARB_RR_EN  defined   : ties go to the requester not granted last
//                                   (round-robin; the last-grant register
//                                   resets to IFU).
//                       undefined : ties always go to the LSU.
//   Both builds hand the first tie after reset to the LSU.
//
// Ports:
//   ACLK        in   clock; all state updates on the rising edge
//   ARESETn     in   synchronous, active-low reset
//   ifu_req     in   instruction-fetch read request
//   ifu_addr    in   instruction-fetch read address   [ADDR_W]
//   ifu_valid   out  one-cycle completion strobe for the IFU
//   ifu_rdata   out  last read data returned to the IFU  [DATA_W]
//   lsu_req     in   load read request
//   lsu_addr    in   load read address                [ADDR_W]
//   lsu_valid   out  one-cycle completion strobe for the LSU
//   lsu_rdata   out  last read data returned to the LSU  [DATA_W]
//   m_arvalid   out  AR channel valid
//   m_arready   in   AR channel ready
//   m_araddr    out  AR channel address                [ADDR_W]
//   m_arprot    out  AR channel protection (3'b100 = instruction access)
//   m_rvalid    in   R channel valid
//   m_rready    out  R channel ready
//   m_rlast     in   R channel last beat of the burst
//   m_rdata     in   R channel data                    [DATA_W]
// ---------------------------------------------------------------------------
module mem_read_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              ACLK,
  input  logic              ARESETn,

  input  logic              ifu_req,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req,
  input  logic [ADDR_W-1:0] lsu_addr,
  output logic              lsu_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,

  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic              m_rlast,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [2:0] PROT_IFU = 3'b100;
  localparam logic [2:0] PROT_LSU = 3'b000;

  state_t state;

  // Which requester owns the transaction in flight (1 = LSU, 0 = IFU).
  logic grant_lsu;

  logic ifu_elig;
  logic lsu_elig;
  logic pick_lsu;
  logic tie_to_lsu;

`ifdef MEM_READ_ARB_RR_EN
  // Remembers who won the most recent grant so a tie can favour the other one.
  logic last_grant_lsu;
`endif

  // A requester whose completion strobe is high this cycle is skipped. Its
  // req line is usually still high from the transaction that just finished,
  // and without this mask that stale level would start a duplicate read.
  always_comb begin
    ifu_elig = ifu_req && !ifu_valid;
    lsu_elig = lsu_req && !lsu_valid;
  end

  // Tie-break selection. In the round-robin build the LSU wins a tie only if
  // the IFU had the previous grant. Because last-grant resets to IFU, the
  // first tie after reset goes to the LSU in both builds.
  always_comb begin
`ifdef MEM_READ_ARB_RR_EN
    tie_to_lsu = !last_grant_lsu;
`else
    tie_to_lsu = 1'b1;
`endif
    pick_lsu = 1'b0;
    if (lsu_elig && ifu_elig) begin
      pick_lsu = tie_to_lsu;
    end else if (lsu_elig) begin
      pick_lsu = 1'b1;
    end
  end

  // Main control FSM. Every interface output is a register, so the AR
  // signals stay stable through a stalled handshake and the completion
  // strobes are glitch-free. The requester address is copied at grant time,
  // so later changes on ifu_addr/lsu_addr cannot reach m_araddr. R beats
  // seen outside DATA are ignored because m_rready is low there. A reset in
  // the middle of a transaction simply discards it; no strobe is produced.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      grant_lsu <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_araddr  <= '0;
      m_arprot  <= 3'b000;
      ifu_valid <= 1'b0;
      lsu_valid <= 1'b0;
      ifu_rdata <= '0;
      lsu_rdata <= '0;
    end else begin
      ifu_valid <= 1'b0;
      lsu_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (ifu_elig || lsu_elig) begin
            grant_lsu <= pick_lsu;
            m_araddr  <= pick_lsu ? lsu_addr : ifu_addr;
            m_arprot  <= pick_lsu ? PROT_LSU : PROT_IFU;
            m_arvalid <= 1'b1;
            state     <= ADDR;
          end
        end

        ADDR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= DATA;
          end
        end

        DATA: begin
          // Beats before the last one are accepted and thrown away; only the
          // final beat carries the data that gets returned.
          if (m_rvalid && m_rlast) begin
            m_rready <= 1'b0;
            m_arprot <= 3'b000;
            state    <= IDLE;
            if (grant_lsu) begin
              lsu_rdata <= m_rdata;
              lsu_valid <= 1'b1;
            end else begin
              ifu_rdata <= m_rdata;
              ifu_valid <= 1'b1;
            end
          end
        end

        default: begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b0;
          m_arprot  <= 3'b000;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_READ_ARB_RR_EN
  // The last-grant history updates on every grant, including grants that
  // were not ties, so the rotation follows actual bus ownership.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      last_grant_lsu <= 1'b0;
    end else if (state == IDLE && (ifu_elig || lsu_elig)) begin
      last_grant_lsu <= pick_lsu;
    end
  end
`endif

endmodule

// File: tb/tb_mem_read_arb.sv
// ---------------------------------------------------------------------------
// tb_mem_read_arb
//
// Purpose:
//   Directed bench for mem_read_arb. Each step advances one clock and then
//   samples 1 time unit after the rising edge. Expected values are worked
//   out by hand from the cycle-level behaviour of the arbiter. The tie
//   sequence accounts for MEM_READ_ARB_RR_EN when that macro is defined.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mem_read_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              ACLK;
  logic              ARESETn;
  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_valid;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_valid;
  logic [DATA_W-1:0] lsu_rdata;
  logic              m_arvalid;
  logic              m_arready;
  logic [ADDR_W-1:0] m_araddr;
  logic [2:0]        m_arprot;
  logic              m_rvalid;
  logic              m_rready;
  logic              m_rlast;
  logic [DATA_W-1:0] m_rdata;

  int checks;
  int failures;

  logic [DATA_W-1:0] expIfuRdata;
  logic [DATA_W-1:0] expLsuRdata;
  logic [2:0]        expTieLsu;

  mem_read_arb #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .ifu_req   (ifu_req),
    .ifu_addr  (ifu_addr),
    .ifu_valid (ifu_valid),
    .ifu_rdata (ifu_rdata),
    .lsu_req   (lsu_req),
    .lsu_addr  (lsu_addr),
    .lsu_valid (lsu_valid),
    .lsu_rdata (lsu_rdata),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rlast   (m_rlast),
    .m_rdata   (m_rdata)
  );

  // Free-running clock with a 10-unit period.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Move to 1 time unit past the next rising edge. Registered outputs are
  // settled there, and new inputs are safely ahead of the following edge.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Drive the slave side of the AR/R channels.
  task automatic applyStimulus(input logic arready, input logic rvalid,
                               input logic rlast, input logic [DATA_W-1:0] rdata);
    m_arready = arready;
    m_rvalid  = rvalid;
    m_rlast   = rlast;
    m_rdata   = rdata;
  endtask

  // One comparison: count it, and report and count any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Check every output that must be zero right after a reset edge.
  task automatic checkResetState(input string tag);
    checkOutput({tag, ".arvalid"}, {63'd0, m_arvalid}, 64'd0);
    checkOutput({tag, ".rready"},  {63'd0, m_rready},  64'd0);
    checkOutput({tag, ".araddr"},  {32'd0, m_araddr},  64'd0);
    checkOutput({tag, ".arprot"},  {61'd0, m_arprot},  64'd0);
    checkOutput({tag, ".ifu_valid"}, {63'd0, ifu_valid}, 64'd0);
    checkOutput({tag, ".lsu_valid"}, {63'd0, lsu_valid}, 64'd0);
    checkOutput({tag, ".ifu_rdata"}, ifu_rdata, 64'd0);
    checkOutput({tag, ".lsu_rdata"}, lsu_rdata, 64'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef MEM_READ_ARB_RR_EN
    expTieLsu = 3'b101;
`else
    expTieLsu = 3'b111;
`endif

    // ---------------- Power-on reset ----------------
    ARESETn  = 1'b0;
    ifu_req  = 1'b0;
    ifu_addr = '0;
    lsu_req  = 1'b0;
    lsu_addr = '0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();
    step();
    checkResetState("por");
    ARESETn = 1'b1;
    step();
    checkOutput("idle.arvalid", {63'd0, m_arvalid}, 64'd0);
    expIfuRdata = '0;
    expLsuRdata = '0;

    // ---------------- IFU alone, minimum latency ----------------
    // Cycle 0: request. Cycle 1: ADDR. Cycle 2: DATA. Cycle 3: strobe.
    ifu_req  = 1'b1;
    ifu_addr = 32'h8000_0000;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    step();
    checkOutput("ifu.c1.arvalid", {63'd0, m_arvalid}, 64'd1);
    checkOutput("ifu.c1.araddr",  {32'd0, m_araddr}, 64'h8000_0000);
    checkOutput("ifu.c1.arprot",  {61'd0, m_arprot}, 64'd4);
    checkOutput("ifu.c1.rready",  {63'd0, m_rready}, 64'd0);
    ifu_req = 1'b0;
    step();
    checkOutput("ifu.c2.arvalid", {63'd0, m_arvalid}, 64'd0);
    checkOutput("ifu.c2.rready",  {63'd0, m_rready}, 64'd1);
    checkOutput("ifu.c2.ifu_valid", {63'd0, ifu_valid}, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h1122_3344_5566_7788);
    step();
    expIfuRdata = 64'h1122_3344_5566_7788;
    checkOutput("ifu.c3.ifu_valid", {63'd0, ifu_valid}, 64'd1);
    checkOutput("ifu.c3.ifu_rdata", ifu_rdata, expIfuRdata);
    checkOutput("ifu.c3.lsu_valid", {63'd0, lsu_valid}, 64'd0);
    checkOutput("ifu.c3.rready",    {63'd0, m_rready}, 64'd0);
    checkOutput("ifu.c3.arprot",    {61'd0, m_arprot}, 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();
    checkOutput("ifu.c4.ifu_valid", {63'd0, ifu_valid}, 64'd0);
    checkOutput("ifu.c4.ifu_rdata", ifu_rdata, expIfuRdata);
    checkOutput("ifu.c4.arvalid",   {63'd0, m_arvalid}, 64'd0);

    // ---------------- Three ties in a row ----------------
    // Both requests are held for each transaction and dropped in the strobe
    // cycle, so every grant decision is a tie.
    ifu_addr = 32'h0000_1000;
    lsu_addr = 32'h0000_2000;
    for (int k = 0; k < 3; k++) begin
      ifu_req = 1'b1;
      lsu_req = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      step();
      checkOutput($sformatf("tie%0d.araddr", k), {32'd0, m_araddr},
                  expTieLsu[k] ? 64'h2000 : 64'h1000);
      checkOutput($sformatf("tie%0d.arprot", k), {61'd0, m_arprot},
                  expTieLsu[k] ? 64'd0 : 64'd4);
      step();
      applyStimulus(1'b0, 1'b1, 1'b1, 64'hA0 + 64'(k));
      step();
      if (expTieLsu[k]) expLsuRdata = 64'hA0 + 64'(k);
      else              expIfuRdata = 64'hA0 + 64'(k);
      checkOutput($sformatf("tie%0d.lsu_valid", k), {63'd0, lsu_valid},
                  {63'd0, expTieLsu[k]});
      checkOutput($sformatf("tie%0d.ifu_valid", k), {63'd0, ifu_valid},
                  {63'd0, !expTieLsu[k]});
      checkOutput($sformatf("tie%0d.lsu_rdata", k), lsu_rdata, expLsuRdata);
      checkOutput($sformatf("tie%0d.ifu_rdata", k), ifu_rdata, expIfuRdata);
      ifu_req = 1'b0;
      lsu_req = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      step();
    end

    // ---------------- Stalled AR handshake, address changes meanwhile ----------------
    lsu_req  = 1'b1;
    lsu_addr = 32'h0000_3000;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();
    lsu_req  = 1'b0;
    lsu_addr = 32'h0000_4444;
    for (int w = 0; w < 4; w++) begin
      checkOutput($sformatf("stall%0d.arvalid", w), {63'd0, m_arvalid}, 64'd1);
      checkOutput($sformatf("stall%0d.araddr", w), {32'd0, m_araddr}, 64'h3000);
      if (w == 3) applyStimulus(1'b1, 1'b0, 1'b0, '0);
      step();
    end
    checkOutput("stall.data.arvalid", {63'd0, m_arvalid}, 64'd0);
    checkOutput("stall.data.rready",  {63'd0, m_rready}, 64'd1);
    checkOutput("stall.data.lsu_valid", {63'd0, lsu_valid}, 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h55);
    step();
    expLsuRdata = 64'h55;
    checkOutput("stall.lsu_valid", {63'd0, lsu_valid}, 64'd1);
    checkOutput("stall.lsu_rdata", lsu_rdata, expLsuRdata);
    checkOutput("stall.ifu_rdata", ifu_rdata, expIfuRdata);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();

    // ---------------- Two-beat burst ----------------
    lsu_req  = 1'b1;
    lsu_addr = 32'h0000_5000;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    step();
    lsu_req = 1'b0;
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 64'hAA);
    step();
    checkOutput("burst.b0.lsu_valid", {63'd0, lsu_valid}, 64'd0);
    checkOutput("burst.b0.rready",    {63'd0, m_rready}, 64'd1);
    checkOutput("burst.b0.lsu_rdata", lsu_rdata, expLsuRdata);
    applyStimulus(1'b0, 1'b1, 1'b1, 64'hBB);
    step();
    expLsuRdata = 64'hBB;
    checkOutput("burst.b1.lsu_valid", {63'd0, lsu_valid}, 64'd1);
    checkOutput("burst.b1.lsu_rdata", lsu_rdata, expLsuRdata);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();
    checkOutput("burst.after.lsu_valid", {63'd0, lsu_valid}, 64'd0);

    // ---------------- Reset during DATA ----------------
    ifu_req  = 1'b1;
    ifu_addr = 32'h0000_6000;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    step();
    ifu_req = 1'b0;
    step();
    checkOutput("rst.pre.rready", {63'd0, m_rready}, 64'd1);
    ARESETn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();
    checkResetState("midrst");
    expIfuRdata = '0;
    expLsuRdata = '0;
    ARESETn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 64'hDEAD);
    step();
    checkOutput("rst.late.ifu_valid", {63'd0, ifu_valid}, 64'd0);
    checkOutput("rst.late.rready",    {63'd0, m_rready}, 64'd0);
    step();
    checkOutput("rst.late2.ifu_valid", {63'd0, ifu_valid}, 64'd0);
    checkOutput("rst.late2.ifu_rdata", ifu_rdata, expIfuRdata);
    checkOutput("rst.late2.arvalid",   {63'd0, m_arvalid}, 64'd0);

    // The next request after reset is served normally.
    ifu_req  = 1'b1;
    ifu_addr = 32'h0000_7000;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    step();
    checkOutput("post.araddr", {32'd0, m_araddr}, 64'h7000);
    checkOutput("post.arprot", {61'd0, m_arprot}, 64'd4);
    ifu_req = 1'b0;
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h77);
    step();
    expIfuRdata = 64'h77;
    checkOutput("post.ifu_valid", {63'd0, ifu_valid}, 64'd1);
    checkOutput("post.ifu_rdata", ifu_rdata, expIfuRdata);
    checkOutput("post.lsu_rdata", lsu_rdata, expLsuRdata);
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_read_arb.md
MEM_READ_ARB -- requirements
Module: mem_read_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request/bus address width.
REQ-002 SHALL have parameter DATA_W, default 64, read data width.
REQ-003 SHALL have port ACLK  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port ARESETn  in  1  reset; synchronous, active-low.
REQ-005 SHALL have ports ifu_req in 1, ifu_addr in ADDR_W, ifu_valid out 1, ifu_rdata out DATA_W: instruction-fetch requester.
REQ-006 SHALL have ports lsu_req in 1, lsu_addr in ADDR_W, lsu_valid out 1, lsu_rdata out DATA_W: load requester.
REQ-007 SHALL have AR channel ports m_arvalid out 1, m_arready in 1, m_araddr out ADDR_W, m_arprot out 3.
REQ-008 SHALL have R channel ports m_rvalid in 1, m_rready out 1, m_rlast in 1, m_rdata in DATA_W.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, DATA; one outstanding transaction maximum.
REQ-010 IDLE: if any eligible request, SHALL latch grant and its addr, go to ADDR next cycle; else stay IDLE.
REQ-011 A requester SHALL be ineligible in a cycle where its own *_valid is high (no duplicate re-issue on held req).
REQ-012 Simultaneous eligible requests SHALL be resolved per REQ-025; a single request is granted directly.
REQ-013 ADDR: m_arvalid=1, m_araddr=latched addr, both stable until m_arvalid&&m_arready sampled; then go to DATA.
REQ-014 m_arprot SHALL be 3'b100 for an IFU grant, 3'b000 for an LSU grant, 3'b000 in IDLE.
REQ-015 DATA: m_rready=1; beats with m_rlast=0 SHALL be accepted and discarded.
REQ-016 On m_rvalid&&m_rlast in DATA: SHALL register m_rdata into granted requester's *_rdata, pulse its *_valid high exactly one cycle (next cycle), return to IDLE.
REQ-017 Minimum latency: req at cycle 0, arready at cycle 1, rvalid+rlast at cycle 2 -> *_valid at cycle 3.
REQ-018 *_rdata SHALL hold until the next completion for the same requester; the other requester's rdata SHALL be unaffected.
REQ-019 Requester dropping req after grant SHALL NOT abort the transaction; completion still pulses *_valid.
REQ-020 m_arvalid and m_rready SHALL be 0 outside ADDR and DATA respectively.
REQ-021 Addr changes on *_addr after grant SHALL NOT affect m_araddr.

Reset
REQ-022 ARESETn low at a rising edge SHALL force IDLE, m_arvalid=0, m_rready=0, m_araddr=0, m_arprot=0, ifu_valid=0, lsu_valid=0, ifu_rdata=0, lsu_rdata=0, last-grant=IFU.
REQ-023 Reset mid-transaction SHALL drop the transaction with no *_valid pulse; requesters SHALL reissue.
REQ-024 R beats arriving while in IDLE (e.g. after reset) SHALL be ignored.

Configuration
REQ-025 Macro MEM_READ_ARB_RR_EN defined: on tie, grant the requester not granted last (round-robin, last-grant register updated at each grant); undefined: on tie, LSU always wins.
REQ-026 With last-grant reset to IFU, the first tie after reset SHALL go to LSU in both builds.

Verification
REQ-027 IFU only, addr 0x8000_0000, arready immediate, rdata 0x1122334455667788 rlast=1 -> ifu_valid one cycle at cycle 3, ifu_rdata=0x1122334455667788, m_arprot=3'b100 during ADDR.
REQ-028 IFU and LSU together held 3 transactions -> RR build grants LSU,IFU,LSU; fixed build grants LSU three times, IFU starved.
REQ-029 arready delayed 4 cycles, lsu_addr changed during wait -> m_araddr/m_arvalid stable at original addr, lsu_valid after handshake.
REQ-030 2-beat burst (rlast 0 then 1, data 0xAA then 0xBB) -> lsu_rdata=0xBB, single lsu_valid pulse.
REQ-031 ARESETn low for one cycle while in DATA -> all outputs 0 next cycle, no *_valid, later rvalid ignored, new request served normally.
